// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module : mem_access_stage_if
// Brief  : req/ack data-memory port between the MEM stage (master) and memory.
// Rev    : 1.0  initial release
// ============================================================================
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_access_stage
// Brief  : EX/MEM register, req/ack data-memory access with timeout, MEM/WB register.
// Rev    : 1.0  initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  wire                 clk,
    input  wire                 rst,
    mem_access_stage_if.master  dmem,
    input  wire                 ex_mem_read,
    input  wire                 ex_mem_write,
    input  wire  [1:0]          ex_length,
    input  wire                 ex_sign,
    input  wire  [31:0]         ex_alu_result,
    input  wire  [31:0]         ex_store_data,
    input  wire  [4:0]          ex_write_reg,
    input  wire                 ex_reg_write,
    input  wire                 ex_mem_to_reg,
    output logic                mem_stall,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [4:0]          wb_write_reg,
    output logic [31:0]         wb_alu_result,
    output logic [31:0]         wb_load_data,
    output logic                misalign_err,
    output logic                bus_err
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] c_LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_wait_cnt;

    logic        r_mem_read;
    logic        r_mem_write;
    logic [1:0]  r_length;
    logic        r_sign;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic [4:0]  r_write_reg;
    logic        r_reg_write;
    logic        r_mem_to_reg;

    logic        w_ex_start;
    logic        w_r_misaligned;
    logic        w_load;
    logic        w_access;
    logic        w_last;
    logic        w_ack;
    logic        w_abort;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    function automatic logic f_misaligned(input logic [1:0] len, input logic [1:0] a);
        case (len)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

    // A request that sets both read and write is handled as a store.
    assign w_ex_start     = (ex_mem_read | ex_mem_write) & ~f_misaligned(ex_length, ex_alu_result[1:0]);
    assign w_r_misaligned = (r_mem_read | r_mem_write) & f_misaligned(r_length, r_addr[1:0]);
    assign w_load         = r_mem_read & ~r_mem_write;

    assign w_access  = (r_state == S_ACCESS);
    assign w_last    = (r_wait_cnt == c_LAST_WAIT);
    assign w_ack     = w_access & dmem.dmem_ack;
    assign w_abort   = w_access & ~dmem.dmem_ack & w_last;
    assign mem_stall = w_access & ~dmem.dmem_ack & ~w_last;

    always_comb begin
        w_be       = 4'b1111;
        w_wdata    = r_store_data;
        w_load_ext = dmem.dmem_rdata;
        case (r_addr[1:0])
            2'd0:    w_byte = dmem.dmem_rdata[7:0];
            2'd1:    w_byte = dmem.dmem_rdata[15:8];
            2'd2:    w_byte = dmem.dmem_rdata[23:16];
            default: w_byte = dmem.dmem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (r_length)
            2'd0: begin
                w_be       = 4'b0001 << r_addr[1:0];
                w_wdata    = {4{r_store_data[7:0]}};
                w_load_ext = {{24{r_sign & w_byte[7]}}, w_byte};
            end
            2'd1: begin
                w_be       = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{r_store_data[15:0]}};
                w_load_ext = {{16{r_sign & w_half[15]}}, w_half};
            end
            default: begin
                w_be       = 4'b1111;
            end
        endcase
    end

    // Bus fields are forced to zero outside an access so idle/reset presents a quiet port.
    assign dmem.dmem_req   = w_access;
    assign dmem.dmem_we    = w_access & r_mem_write;
    assign dmem.dmem_addr  = w_access ? {r_addr[31:2], 2'b00} : 32'd0;
    assign dmem.dmem_be    = w_access ? w_be : 4'd0;
    assign dmem.dmem_wdata = (w_access & r_mem_write) ? w_wdata : 32'd0;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_length      <= '0;
            r_sign        <= 1'b0;
            r_addr        <= '0;
            r_store_data  <= '0;
            r_write_reg   <= '0;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_write_reg  <= '0;
            wb_alu_result <= '0;
            wb_load_data  <= '0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
        end else if (mem_stall) begin
            r_wait_cnt    <= r_wait_cnt + 8'd1;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_load_data  <= '0;
            misalign_err  <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            r_state       <= w_ex_start ? S_ACCESS : S_IDLE;
            r_wait_cnt    <= '0;
            r_mem_read    <= ex_mem_read;
            r_mem_write   <= ex_mem_write;
            r_length      <= ex_length;
            r_sign        <= ex_sign;
            r_addr        <= ex_alu_result;
            r_store_data  <= ex_store_data;
            r_write_reg   <= ex_write_reg;
            r_reg_write   <= ex_reg_write;
            r_mem_to_reg  <= ex_mem_to_reg;
            // Retire whatever EX/MEM held; misaligned and aborted ops never write a register.
            wb_reg_write  <= r_reg_write & ~w_r_misaligned & ~w_abort;
            wb_mem_to_reg <= r_mem_to_reg;
            wb_write_reg  <= r_write_reg;
            wb_alu_result <= r_addr;
            wb_load_data  <= (w_load & w_ack) ? w_load_ext : 32'd0;
            misalign_err  <= w_r_misaligned;
            bus_err       <= w_abort;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Transaction-level model bench for mem_access_stage (directed + random ops).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    typedef struct {
        bit        rd_en;
        bit        wr_en;
        bit [1:0]  len;
        bit        sign;
        bit [31:0] addr;
        bit [31:0] data;
        bit [31:0] rdata;
        bit [4:0]  rd;
        bit        rw;
        bit        m2r;
        int        waits;
    } op_t;

    logic        clk;
    logic        rst;
    logic        ex_mem_read, ex_mem_write, ex_sign, ex_reg_write, ex_mem_to_reg;
    logic [1:0]  ex_length;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_write_reg;
    logic        mem_stall, wb_reg_write, wb_mem_to_reg, misalign_err, bus_err;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_alu_result, wb_load_data;

    int  n_vec = 0;
    int  n_err = 0;
    op_t q[$];
    bit  stray_ack = 1'b0;
    int  stall_cycles;
    bit  saw_req, saw_bus_err, saw_misalign;

    mem_access_stage_if dmem_bus ();

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .dmem          (dmem_bus.master),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_length     (ex_length),
        .ex_sign       (ex_sign),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_write_reg  (ex_write_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .mem_stall     (mem_stall),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_write_reg  (wb_write_reg),
        .wb_alu_result (wb_alu_result),
        .wb_load_data  (wb_load_data),
        .misalign_err  (misalign_err),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int f_size(op_t o);
        return (o.len == 2'd0) ? 1 : (o.len == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit f_is_mem(op_t o);
        return o.rd_en || o.wr_en;
    endfunction

    function automatic bit f_misal(op_t o);
        return f_is_mem(o) && ((o.addr % 32'(f_size(o))) != 32'd0);
    endfunction

    function automatic bit f_access(op_t o);
        return f_is_mem(o) && !f_misal(o);
    endfunction

    function automatic bit [3:0] f_be(op_t o);
        int lane;
        lane = int'(o.addr % 32'd4);
        if (f_size(o) == 1) return 4'(1 << lane);
        if (f_size(o) == 2) return (lane == 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic bit [31:0] f_wdata(op_t o);
        if (f_size(o) == 1) return (o.data & 32'hFF) * 32'h0101_0101;
        if (f_size(o) == 2) return (o.data & 32'hFFFF) * 32'h0001_0001;
        return o.data;
    endfunction

    function automatic bit [31:0] f_load(op_t o);
        bit [31:0] v;
        if (!o.rd_en || o.wr_en) return 32'd0;
        v = o.rdata >> (32'd8 * (o.addr % 32'd4));
        if (f_size(o) == 1) begin
            v = v & 32'hFF;
            if (o.sign && v >= 32'h80) v = v - 32'h100;
        end else if (f_size(o) == 2) begin
            v = v & 32'hFFFF;
            if (o.sign && v >= 32'h8000) v = v - 32'h1_0000;
        end
        return v;
    endfunction

    function automatic op_t mk_alu(bit [31:0] res, bit [4:0] rd, bit rw);
        op_t o;
        o = '{default: 0};
        o.addr = res;
        o.rd   = rd;
        o.rw   = rw;
        return o;
    endfunction

    function automatic op_t mk_mem(bit rd_en, bit wr_en, bit [1:0] len, bit sign, bit [31:0] addr,
                                   bit [31:0] data, bit [31:0] rdata, int waits, bit [4:0] rd);
        op_t o;
        o = '{default: 0};
        o.rd_en = rd_en;  o.wr_en = wr_en;  o.len = len;  o.sign = sign;
        o.addr  = addr;   o.data  = data;   o.rdata = rdata;
        o.waits = waits;  o.rd    = rd;
        o.rw    = rd_en && !wr_en;
        o.m2r   = rd_en && !wr_en;
        return o;
    endfunction

    task automatic drive_ex(op_t o);
        ex_mem_read   = o.rd_en;
        ex_mem_write  = o.wr_en;
        ex_length     = o.len;
        ex_sign       = o.sign;
        ex_alu_result = o.addr;
        ex_store_data = o.data;
        ex_write_reg  = o.rd;
        ex_reg_write  = o.rw;
        ex_mem_to_reg = o.m2r;
    endtask

    // Plays q[1..] through the stage; q[0] is whatever EX/MEM already holds.
    task automatic run_ops();
        int  cur = 0;
        int  nxt = 1;
        int  waited = 0;
        int  done_idx = 0;
        bit  have_exp = 1'b0;
        bit  exp_full = 1'b0, exp_rw = 1'b0, exp_mis = 1'b0, exp_berr = 1'b0;
        bit  acc, ack, exp_stall, aborted;
        op_t e;
        e = mk_alu(0, 0, 0);
        stall_cycles = 0;
        saw_req = 1'b0; saw_bus_err = 1'b0; saw_misalign = 1'b0;
        while (cur < q.size()) begin
            @(posedge clk);
            if (have_exp) begin
                n_vec++;
                if (wb_reg_write !== exp_rw) begin
                    n_err++;
                    $display("FAIL wb_reg_write op%0d: got %b expected %b", done_idx, wb_reg_write, exp_rw);
                end
                n_vec++;
                if (misalign_err !== exp_mis) begin
                    n_err++;
                    $display("FAIL misalign_err op%0d: got %b expected %b", done_idx, misalign_err, exp_mis);
                end
                n_vec++;
                if (bus_err !== exp_berr) begin
                    n_err++;
                    $display("FAIL bus_err op%0d: got %b expected %b", done_idx, bus_err, exp_berr);
                end
                if (exp_full) begin
                    n_vec++;
                    if (wb_alu_result !== e.addr || wb_write_reg !== e.rd || wb_mem_to_reg !== e.m2r) begin
                        n_err++;
                        $display("FAIL wb_fields op%0d: got alu=%h rd=%0d m2r=%b expected alu=%h rd=%0d m2r=%b",
                                 done_idx, wb_alu_result, wb_write_reg, wb_mem_to_reg, e.addr, e.rd, e.m2r);
                    end
                    n_vec++;
                    if (wb_load_data !== f_load(e)) begin
                        n_err++;
                        $display("FAIL wb_load_data op%0d: got %h expected %h", done_idx, wb_load_data, f_load(e));
                    end
                end
            end
            saw_req      |= (dmem_bus.dmem_req === 1'b1);
            saw_bus_err  |= (bus_err === 1'b1);
            saw_misalign |= (misalign_err === 1'b1);
            if (cur == q.size() - 1) break;

            drive_ex(q[nxt]);
            acc = f_access(q[cur]);
            n_vec++;
            if (dmem_bus.dmem_req !== acc) begin
                n_err++;
                $display("FAIL dmem_req op%0d: got %b expected %b", cur, dmem_bus.dmem_req, acc);
            end
            if (acc) begin
                n_vec++;
                if (dmem_bus.dmem_addr !== (q[cur].addr & 32'hFFFF_FFFC) || dmem_bus.dmem_be !== f_be(q[cur])
                    || dmem_bus.dmem_we !== q[cur].wr_en) begin
                    n_err++;
                    $display("FAIL dmem_cmd op%0d: got addr=%h be=%b we=%b expected addr=%h be=%b we=%b", cur,
                             dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_we,
                             q[cur].addr & 32'hFFFF_FFFC, f_be(q[cur]), q[cur].wr_en);
                end
                if (q[cur].wr_en) begin
                    n_vec++;
                    if (dmem_bus.dmem_wdata !== f_wdata(q[cur])) begin
                        n_err++;
                        $display("FAIL dmem_wdata op%0d: got %h expected %h", cur, dmem_bus.dmem_wdata, f_wdata(q[cur]));
                    end
                end
            end
            ack = acc && (waited == q[cur].waits);
            dmem_bus.dmem_ack   = ack || (stray_ack && !acc);
            dmem_bus.dmem_rdata = q[cur].rdata;
            #1;
            exp_stall = acc && !ack && (waited != TIMEOUT - 1);
            n_vec++;
            if (mem_stall !== exp_stall) begin
                n_err++;
                $display("FAIL mem_stall op%0d wait%0d: got %b expected %b", cur, waited, mem_stall, exp_stall);
            end
            if (mem_stall === 1'b1) stall_cycles++;
            have_exp = 1'b1;
            if (exp_stall) begin
                waited++;
                exp_full = 1'b0; exp_rw = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
            end else begin
                e        = q[cur];
                done_idx = cur;
                aborted  = acc && (e.waits >= TIMEOUT);
                exp_mis  = f_misal(e);
                exp_berr = aborted;
                exp_full = !exp_mis && !aborted;
                exp_rw   = e.rw && exp_full;
                cur      = nxt;
                nxt++;
                waited   = 0;
            end
            @(negedge clk);
            #1;
        end
        dmem_bus.dmem_ack = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive_ex(mk_alu(0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_wdata,
             mem_stall, wb_reg_write, wb_mem_to_reg, wb_write_reg, wb_alu_result, wb_load_data,
             misalign_err, bus_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b stall=%b wb_rw=%b alu=%h ld=%h expected all zero",
                     dmem_bus.dmem_req, mem_stall, wb_reg_write, wb_alu_result, wb_load_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_alu_passthrough();
        q.delete();
        q.push_back(mk_alu(0, 0, 0));
        q.push_back(mk_alu(32'h10, 5'd5, 1'b1));
        q.push_back(mk_alu(0, 0, 0));
        run_ops();
        n_vec++;
        if (saw_req || stall_cycles != 0) begin
            n_err++;
            $display("FAIL alu_no_access: got req_seen=%b stalls=%0d expected 0 and 0", saw_req, stall_cycles);
        end
    endtask

    task automatic test_store_byte();
        q.delete();
        q.push_back(mk_alu(0, 0, 0));
        q.push_back(mk_mem(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AB, 32'h0, 0, 5'd0));
        q.push_back(mk_alu(0, 0, 0));
        run_ops();
        n_vec++;
        if (stall_cycles != 0 || !saw_req) begin
            n_err++;
            $display("FAIL sb_zero_wait: got stalls=%0d req_seen=%b expected 0 and 1", stall_cycles, saw_req);
        end
    endtask

    task automatic test_load_half_wait();
        q.delete();
        q.push_back(mk_alu(0, 0, 0));
        q.push_back(mk_mem(1'b1, 1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'h8001_1234, 3, 5'd7));
        q.push_back(mk_alu(0, 0, 0));
        run_ops();
        n_vec++;
        if (stall_cycles != 3) begin
            n_err++;
            $display("FAIL lh_stall_cycles: got %0d expected 3", stall_cycles);
        end
    endtask

    task automatic test_misaligned();
        q.delete();
        q.push_back(mk_alu(0, 0, 0));
        q.push_back(mk_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h305, 32'h0, 32'hDEAD_BEEF, 0, 5'd9));
        q.push_back(mk_mem(1'b0, 1'b1, 2'd1, 1'b0, 32'h401, 32'h1234, 32'h0, 0, 5'd0));
        q.push_back(mk_alu(0, 0, 0));
        run_ops();
        n_vec++;
        if (saw_req || !saw_misalign) begin
            n_err++;
            $display("FAIL misaligned_drop: got req_seen=%b misalign_seen=%b expected 0 and 1", saw_req, saw_misalign);
        end
    endtask

    task automatic test_timeout();
        stray_ack = 1'b1;
        q.delete();
        q.push_back(mk_alu(0, 0, 0));
        q.push_back(mk_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h1111_2222, 1000, 5'd3));
        q.push_back(mk_alu(32'h77, 5'd4, 1'b1));
        q.push_back(mk_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1, 5'd6));
        q.push_back(mk_alu(0, 0, 0));
        run_ops();
        stray_ack = 1'b0;
        n_vec++;
        if (stall_cycles != 2 * (TIMEOUT - 1) || !saw_bus_err) begin
            n_err++;
            $display("FAIL timeout_stalls: got stalls=%0d bus_err_seen=%b expected %0d and 1",
                     stall_cycles, saw_bus_err, 2 * (TIMEOUT - 1));
        end
    endtask

    task automatic test_back_to_back();
        q.delete();
        q.push_back(mk_alu(0, 0, 0));
        q.push_back(mk_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 32'h0BAD_CAFE, 0, 5'd1));
        q.push_back(mk_mem(1'b0, 1'b1, 2'd2, 1'b0, 32'h604, 32'h1357_9BDF, 32'h0, 0, 5'd0));
        q.push_back(mk_mem(1'b1, 1'b0, 2'd0, 1'b0, 32'h607, 32'h0, 32'hF1E2_D3C4, 2, 5'd2));
        q.push_back(mk_mem(1'b1, 1'b1, 2'd1, 1'b0, 32'h60A, 32'hABCD_5678, 32'h0, 0, 5'd0));
        q.push_back(mk_alu(32'h1234_5678, 5'd31, 1'b1));
        q.push_back(mk_alu(0, 0, 0));
        run_ops();
        n_vec++;
        if (stall_cycles != 2) begin
            n_err++;
            $display("FAIL b2b_stall_cycles: got %0d expected 2", stall_cycles);
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk);
        drive_ex(mk_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h700, 32'h0, 32'h0, 1000, 5'd8));
        dmem_bus.dmem_ack = 1'b0;
        @(posedge clk);
        drive_ex(mk_alu(0, 0, 0));
        n_vec++;
        if (dmem_bus.dmem_req !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_req_before: got %b expected 1", dmem_bus.dmem_req);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_wdata,
             mem_stall, wb_reg_write, wb_mem_to_reg, wb_write_reg, wb_alu_result, wb_load_data,
             misalign_err, bus_err} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got req=%b stall=%b wb_rw=%b alu=%h expected all zero",
                     dmem_bus.dmem_req, mem_stall, wb_reg_write, wb_alu_result);
        end
        @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        q.delete();
        q.push_back(mk_alu(0, 0, 0));
        q.push_back(mk_alu(32'h42, 5'd10, 1'b1));
        q.push_back(mk_mem(1'b1, 1'b0, 2'd0, 1'b1, 32'h801, 32'h0, 32'h0000_9000, 1, 5'd11));
        q.push_back(mk_alu(0, 0, 0));
        run_ops();
    endtask

    task automatic test_random();
        op_t o;
        int  kind, sel, sz;
        q.delete();
        q.push_back(mk_alu(0, 0, 0));
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 9);
            o = mk_mem(kind >= 3 && kind != 6, kind >= 6, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, $urandom,
                       (sel < 7) ? $urandom_range(0, 3) : (sel == 7) ? TIMEOUT - 1 : TIMEOUT + 2,
                       5'($urandom_range(0, 31)));
            if (kind < 3) o = mk_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            sz = f_size(o);
            if ($urandom_range(0, 4) != 0) o.addr = o.addr & ~(32'(sz) - 32'd1);
            q.push_back(o);
        end
        q.push_back(mk_alu(0, 0, 0));
        run_ops();
    endtask

    initial begin
        rst = 1'b0;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'd0;
        test_reset();
        test_alu_passthrough();
        test_store_byte();
        test_load_half_wait();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
